// File: rtl/bp_table_ctrl.sv
// Branch-predictor table write sequencer: sweep after reset or flush, then read-modify-write training from a small FIFO (push to write 3 cycles, 1 update per 3 cycles).
// A full FIFO drops updates silently because there is no backpressure. Define BP_STATS_EN to add update and drop counters.
module bp_table_ctrl #(
    parameter int BHT_DEPTH  = 10,
    parameter int PHT_DEPTH  = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_req,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_take,
    output logic [BHT_DEPTH-1:0] bht_raddr,
    input  logic [PHT_DEPTH-1:0] bht_rdata,
    output logic [PHT_DEPTH-1:0] pht_raddr,
    input  logic [1:0]           pht_rdata,
    output logic                 bht_we,
    output logic [BHT_DEPTH-1:0] bht_waddr,
    output logic [PHT_DEPTH-1:0] bht_wdata,
    output logic                 pht_we,
    output logic [PHT_DEPTH-1:0] pht_waddr,
    output logic [1:0]           pht_wdata,
`ifdef BP_STATS_EN
    output logic [31:0]          stat_upd_cnt,
    output logic [31:0]          stat_drop_cnt,
`endif
    output logic                 table_ready
);
    localparam int MAX_DEPTH = (BHT_DEPTH > PHT_DEPTH) ? BHT_DEPTH : PHT_DEPTH;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int ENT_W     = MAX_DEPTH + 1;

    typedef enum logic [1:0] {SWEEP, IDLE, PHT_RD, WRITE} state_t;

    state_t               state;
    logic [MAX_DEPTH-1:0] sweepIdx;
    logic [ENT_W-1:0]     fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rdPtr;
    logic [PTR_W-1:0]     wrPtr;
    logic [PTR_W:0]       count;
    logic [MAX_DEPTH-1:0] workPc;
    logic                 workTake;
    logic [PHT_DEPTH-1:0] hist;
    logic [PHT_DEPTH-1:0] phtIdx;
    logic [ENT_W-1:0]     headEnt;
    logic [ENT_W-1:0]     pushEnt;
    logic                 doPop;
    logic                 doPush;
    logic                 doWrite;
    logic [1:0]           phtNext;
    logic                 unusedBits;

    assign headEnt = fifoMem[rdPtr];
    assign pushEnt = {upd_pc[MAX_DEPTH+1:2], upd_take};
    assign doPop   = !rst && !flush_req && (state == IDLE) && (count != '0);
    assign doPush  = !rst && !flush_req && upd_valid && (state != SWEEP) &&
                     ((count < (PTR_W+1)'(FIFO_DEPTH)) || doPop);
    assign doWrite = !rst && !flush_req && (state == WRITE);
    assign unusedBits = ^{upd_pc[31:MAX_DEPTH+2], upd_pc[1:0], hist[PHT_DEPTH-1]};

    always_comb begin
        phtNext = pht_rdata;
        if (workTake) begin
            if (pht_rdata != 2'b11) phtNext = pht_rdata + 2'd1;
        end else if (pht_rdata != 2'b00) begin
            phtNext = pht_rdata - 2'd1;
        end
    end

    // Table ports decode straight from state so the RAM read latency fits the 3-cycle budget.
    always_comb begin
        bht_raddr = '0;
        pht_raddr = '0;
        bht_we    = 1'b0;
        bht_waddr = '0;
        bht_wdata = '0;
        pht_we    = 1'b0;
        pht_waddr = '0;
        pht_wdata = '0;
        if (!rst) begin
            case (state)
                SWEEP: begin
                    bht_we    = (sweepIdx >> BHT_DEPTH) == '0;
                    bht_waddr = sweepIdx[BHT_DEPTH-1:0];
                    pht_we    = (sweepIdx >> PHT_DEPTH) == '0;
                    pht_waddr = sweepIdx[PHT_DEPTH-1:0];
                    pht_wdata = 2'b10;
                end
                IDLE:   bht_raddr = headEnt[BHT_DEPTH:1];
                PHT_RD: pht_raddr = workPc[PHT_DEPTH-1:0] ^ bht_rdata;
                WRITE: begin
                    bht_we    = doWrite;
                    bht_waddr = workPc[BHT_DEPTH-1:0];
                    bht_wdata = {hist[PHT_DEPTH-2:0], workTake};
                    pht_we    = doWrite;
                    pht_waddr = phtIdx;
                    pht_wdata = phtNext;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_req) begin
            state       <= SWEEP;
            sweepIdx    <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            table_ready <= 1'b0;
        end else begin
            if (doPush) begin
                fifoMem[wrPtr] <= pushEnt;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (doPop) rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;

            case (state)
                SWEEP: begin
                    sweepIdx <= sweepIdx + 1'b1;
                    if (&sweepIdx) begin
                        state       <= IDLE;
                        table_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (doPop) begin
                        workPc   <= headEnt[ENT_W-1:1];
                        workTake <= headEnt[0];
                        state    <= PHT_RD;
                    end
                end
                PHT_RD: begin
                    hist   <= bht_rdata;
                    phtIdx <= pht_raddr;
                    state  <= WRITE;
                end
                WRITE:   state <= IDLE;
                default: state <= SWEEP;
            endcase
        end
    end

`ifdef BP_STATS_EN
    // Flush leaves these alone so drops across a re-sweep stay visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_upd_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (doWrite && !(&stat_upd_cnt)) stat_upd_cnt <= stat_upd_cnt + 32'd1;
            if (upd_valid && !doPush && !(&stat_drop_cnt)) stat_drop_cnt <= stat_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/bp_table_ctrl.md
Name: bp_table_ctrl

Overview:
- Sequences all writes to the branch-predictor history tables: the BHT (per-PC local history) and the PHT (2-bit counters, indexed by PC XOR history).
- The tables are single-write-port synchronous-read RAMs, so initialisation uses a multi-cycle sweep instead of reset loops.
- M-stage training updates are queued in a small FIFO and serialised as read-modify-write sequences.
- Sits between the M-stage branch resolution signals and the table RAMs; tells the fetch predictor when table contents are valid.

Parameters:
- BHT_DEPTH, 10, log2 of BHT entries; BHT index = pc[BHT_DEPTH+1:2].
- PHT_DEPTH, 6, log2 of PHT entries; also BHT entry width (history bits).
- FIFO_DEPTH, 4, update queue entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_req  in  1  one-cycle pulse: discard queued training and re-sweep the tables
- upd_valid  in  1  M-stage branch resolved (branchM, unstalled)
- upd_pc  in  32  PC of the resolved branch
- upd_take  in  1  actual direction
- bht_raddr  out  BHT_DEPTH  BHT read address; data returned next cycle
- bht_rdata  in  PHT_DEPTH  BHT read data
- pht_raddr  out  PHT_DEPTH  PHT read address; data returned next cycle
- pht_rdata  in  2  PHT read data
- bht_we  out  1  BHT write enable
- bht_waddr  out  BHT_DEPTH  BHT write address
- bht_wdata  out  PHT_DEPTH  BHT write data
- pht_we  out  1  PHT write enable
- pht_waddr  out  PHT_DEPTH  PHT write address
- pht_wdata  out  2  PHT write data
- table_ready  out  1  tables valid; predictor forces not-taken while low

Behaviour:
- Reset: state=SWEEP, sweep counter=0, FIFO empty, table_ready=0. All we outputs are 0 in the reset cycle.
- SWEEP, one index per cycle, counter i from 0 to 2^max(BHT_DEPTH,PHT_DEPTH)-1:
  - bht_we=1, waddr=i, wdata=0 when i < 2^BHT_DEPTH.
  - pht_we=1, waddr=i, wdata=2'b10 (weakly taken) when i < 2^PHT_DEPTH.
  - After the last index, go to IDLE; table_ready=1 from the next cycle.
  - Defaults: 1024 sweep cycles.
- FIFO push: if upd_valid, the entry {pc[max+1:2], take} is accepted iff state!=SWEEP, flush_req=0, and (count<FIFO_DEPTH or a pop occurs in the same cycle). Otherwise the update is dropped silently.
- IDLE, FIFO not empty:
  - Pop the head into a work register.
  - bht_raddr = head pc[BHT_DEPTH+1:2].
  - Next state: PHT_RD.
- PHT_RD:
  - Latch hist = bht_rdata.
  - pht_raddr = pc[PHT_DEPTH+1:2] ^ bht_rdata.
  - Next state: WRITE.
- WRITE (single cycle), then IDLE:
  - bht_we=1, bht_waddr = BHT index, bht_wdata = {hist[PHT_DEPTH-2:0], take}.
  - pht_we=1, pht_waddr = the PHT index from PHT_RD.
  - pht_wdata = saturating counter: take → min(pht_rdata+1, 3); not take → max(pht_rdata-1, 0).
- Timing: a push accepted in cycle t, with the controller idle and the FIFO empty, produces its write in cycle t+3. Throughput is 1 update per 3 cycles.
- Ordering: strict FIFO order. An update's write completes before the next update's BHT read, so same-entry back-to-back updates see fresh data.
- flush_req, any state:
  - The in-flight update is abandoned with no write.
  - The FIFO is cleared and a push in the same cycle is dropped.
  - Next cycle: state=SWEEP, counter=0, table_ready=0.
  - A flush during SWEEP restarts the sweep from 0.
- rst overrides flush_req.
- Address outputs are don't-care when not in use. They are driven 0 in reset and SWEEP.

Optional Feature:
- BP_STATS_EN defined: adds outputs stat_upd_cnt[31:0] (writes performed in WRITE) and stat_drop_cnt[31:0] (upd_valid cycles not accepted).
  - Both are saturating, cleared by rst only (not by flush_req).
- BP_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release → table_ready=0 for 1024 cycles.
  - bht_we each cycle, waddr 0..1023, wdata 0.
  - pht_we for cycles 0..63 only, wdata 2'b10.
  - table_ready=1 on cycle 1024.
- After sweep, push pc=0x0000_0010 take=1 at cycle t (model bht=0, pht=2'b10) → cycle t+3: bht_waddr=4 wdata=6'b000001, pht_waddr=4 wdata=2'b11.
- Same pc pushed again take=1 right after the first write → pht_raddr=4^1=5; BHT wdata=6'b000011.
- 10 consecutive pushes starting cycle 0 with FIFO empty → pushes at cycles 6, 8, 9 dropped.
  - 7 writes total, at cycles 3, 6, 9, ...
  - stat_drop_cnt=3 with BP_STATS_EN.
- flush_req asserted in PHT_RD with 2 entries queued → no WRITE.
  - table_ready=0 next cycle; sweep restarts at index 0.
  - The queued entries are never written.
- 3 pushes during SWEEP → no update writes after the sweep; stat_drop_cnt=3.
